prbs26_checker: RTL and testbench

- Receive-side companion to the 26-bit PRBS generator: accepts its serial output stream (generator stage 26, one bit per valid cycle), self-synchronises and counts bit errors.
- Polynomial p(x) = x^26 + x^8 + x^7 + x + 1.
- Sits at the end of a loopback or serial link path; drives lock and error-statistics registers.

---
 rtl/prbs26_pkg.sv | 23 ++
 rtl/prbs26_predictor.sv | 30 +++
 rtl/prbs26_checker.sv | 137 +++++++++++++
 tb/tb_prbs26_checker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs26_pkg.sv
// rtl/prbs26_pkg.sv - shared constants, state encoding and saturating increment for the PRBS26 checker
package prbs26_pkg;

   localparam int PRBS_LEN = 26;
   localparam int TAP_A    = 25;
   localparam int TAP_B    = 24;
   localparam int TAP_C    = 18;
   localparam int TAP_D    = 17;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   // Increment a counter of the given width, holding at all-ones.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
      logic [31:0] max_value;
      max_value = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (value == max_value) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/prbs26_predictor.sv
// rtl/prbs26_predictor.sv - 26-bit history register and next-bit predictor for x^26+x^8+x^7+x+1
module prbs26_predictor
   import prbs26_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic shift_en,
   input  logic use_pred,
   input  logic din,
   output logic pred,
   output logic next_nonzero
);

   logic [PRBS_LEN-1:0] hist;
   logic                shift_bit;

   assign pred         = hist[TAP_A] ^ hist[TAP_B] ^ hist[TAP_C] ^ hist[TAP_D];
   assign shift_bit    = use_pred ? pred : din;
   // Nonzero test of the history as it would look after shifting in din.
   assign next_nonzero = |{hist[PRBS_LEN-2:0], din};

   always_ff @(posedge clk) begin
      if (rst) begin
         hist <= '0;
      end else if (shift_en) begin
         hist <= {hist[PRBS_LEN-2:0], shift_bit};
      end
   end

endmodule

// File: rtl/prbs26_checker.sv
// rtl/prbs26_checker.sv - self-synchronising PRBS26 checker with lock and error statistics
// Optional bit_count output enabled by PRBS26_CHK_BITCNT_EN.
module prbs26_checker
   import prbs26_pkg::*;
#(
   parameter int VERIFY_LEN  = 32,
   parameter int WIN_LEN     = 64,
   parameter int LOSS_THRESH = 8,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din_valid,
   input  logic             din,
   input  logic             clr_cnt,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_count
`ifdef PRBS26_CHK_BITCNT_EN
   ,
   output logic [CNT_W-1:0] bit_count
`endif
);

   state_t      state, state_nxt;
   logic [4:0]  fill, fill_nxt;
   logic [7:0]  verify_cnt, verify_nxt;
   logic [15:0] win_cnt, win_nxt;
   logic [15:0] win_err, win_err_nxt;
   logic        pred;
   logic        next_nonzero;
   logic        mismatch;

   prbs26_predictor u_predictor (
      .clk          (clk),
      .rst          (rst),
      .shift_en     (din_valid),
      .use_pred     (state == LOCKED),
      .din          (din),
      .pred         (pred),
      .next_nonzero (next_nonzero)
   );

   assign locked = (state == LOCKED);

   always_comb begin
      state_nxt   = state;
      fill_nxt    = fill;
      verify_nxt  = verify_cnt;
      win_nxt     = win_cnt;
      win_err_nxt = win_err;
      mismatch    = 1'b0;
      if (din_valid) begin
         case (state)
            HUNT: begin
               // Once the history is full, every new bit re-tests for the all-zero lockup.
               if (fill >= 5'(PRBS_LEN - 1)) begin
                  fill_nxt = 5'(PRBS_LEN);
                  if (next_nonzero) begin
                     state_nxt  = VERIFY;
                     verify_nxt = '0;
                  end
               end else begin
                  fill_nxt = fill + 5'd1;
               end
            end
            VERIFY: begin
               if (din == pred) begin
                  verify_nxt = verify_cnt + 8'd1;
                  if (verify_cnt == 8'(VERIFY_LEN - 1)) begin
                     state_nxt   = LOCKED;
                     win_nxt     = '0;
                     win_err_nxt = '0;
                  end
               end else begin
                  state_nxt = HUNT;
                  fill_nxt  = '0;
               end
            end
            LOCKED: begin
               mismatch = (din != pred);
               if (mismatch && (win_err == 16'(LOSS_THRESH - 1))) begin
                  state_nxt   = HUNT;
                  fill_nxt    = '0;
                  win_nxt     = '0;
                  win_err_nxt = '0;
               end else if (win_cnt == 16'(WIN_LEN - 1)) begin
                  win_nxt     = '0;
                  win_err_nxt = '0;
               end else begin
                  win_nxt     = win_cnt + 16'd1;
                  win_err_nxt = win_err + 16'(mismatch);
               end
            end
            default: begin
               state_nxt = HUNT;
               fill_nxt  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= HUNT;
         fill       <= '0;
         verify_cnt <= '0;
         win_cnt    <= '0;
         win_err    <= '0;
         err        <= 1'b0;
         err_count  <= '0;
      end else begin
         state      <= state_nxt;
         fill       <= fill_nxt;
         verify_cnt <= verify_nxt;
         win_cnt    <= win_nxt;
         win_err    <= win_err_nxt;
         err        <= mismatch;
         if (clr_cnt) begin
            err_count <= '0;
         end else if (mismatch) begin
            err_count <= CNT_W'(sat_inc(32'(err_count), CNT_W));
         end
      end
   end

`ifdef PRBS26_CHK_BITCNT_EN
   always_ff @(posedge clk) begin
      if (rst || clr_cnt) begin
         bit_count <= '0;
      end else if (din_valid && (state == LOCKED)) begin
         bit_count <= CNT_W'(sat_inc(32'(bit_count), CNT_W));
      end
   end
`endif

endmodule

// File: tb/tb_prbs26_checker.sv
// tb/tb_prbs26_checker.sv - directed self-checking bench for prbs26_checker
module tb_prbs26_checker;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             din_valid = 1'b0;
   logic             din = 1'b0;
   logic             clr_cnt = 1'b0;
   logic             locked;
   logic             err;
   logic [CNT_W-1:0] err_count;
`ifdef PRBS26_CHK_BITCNT_EN
   logic [CNT_W-1:0] bit_count;
`endif

   int          checks = 0;
   int          errors = 0;
   int          err_pulses = 0;
   logic [25:0] g = 26'h1;

   always #5 clk = ~clk;

   prbs26_checker #(
      .VERIFY_LEN  (32),
      .WIN_LEN     (64),
      .LOSS_THRESH (8),
      .CNT_W       (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .din_valid (din_valid),
      .din       (din),
      .clr_cnt   (clr_cnt),
      .locked    (locked),
      .err       (err),
      .err_count (err_count)
`ifdef PRBS26_CHK_BITCNT_EN
      ,
      .bit_count (bit_count)
`endif
   );

   // One clock cycle: drive on the falling edge, sample 1ns after the rising edge.
   task automatic step(input logic v, input logic flip, input logic clr);
      @(negedge clk);
      din_valid = v;
      clr_cnt   = clr;
      din       = v ? (g[25] ^ flip) : ~g[25];
      if (v) g = {g[24:0], g[25] ^ g[24] ^ g[18] ^ g[17]};
      @(posedge clk);
      #1;
      if (err === 1'b1) err_pulses++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      rst = 1'b0;
      err_pulses = 0;
   endtask

   task automatic lock_up();
      do_reset();
      g = 26'h1;
      repeat (58) step(1'b1, 1'b0, 1'b0);
      err_pulses = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step(1'b1, 1'b1, 1'b0);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count: got %0d expected 0", err_count); end
`ifdef PRBS26_CHK_BITCNT_EN
      checks++; if (bit_count !== 8'd0) begin errors++; $display("FAIL reset_bit_count: got %0d expected 0", bit_count); end
`endif
      rst = 1'b0;
   endtask

   task automatic test_clean_lock();
      do_reset();
      g = 26'h1;
      repeat (57) step(1'b1, 1'b0, 1'b0);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL clean_lock_early: got %b expected 0", locked); end
      step(1'b1, 1'b0, 1'b0);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clean_lock_at_58: got %b expected 1", locked); end
      err_pulses = 0;
      repeat (1000) step(1'b1, 1'b0, 1'b0);
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL clean_err_count: got %0d expected 0", err_count); end
      checks++; if (err_pulses !== 0) begin errors++; $display("FAIL clean_err_pulses: got %0d expected 0", err_pulses); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clean_still_locked: got %b expected 1", locked); end
   endtask

   task automatic test_single_error();
      lock_up();
      for (int i = 1; i <= 300; i++) begin
         step(1'b1, i == 200, 1'b0);
         if (i == 200) begin
            checks++; if (err !== 1'b1) begin errors++; $display("FAIL single_err_pulse: got %b expected 1", err); end
         end
         if (i == 201) begin
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err_one_cycle: got %b expected 0", err); end
         end
      end
      checks++; if (err_pulses !== 1) begin errors++; $display("FAIL single_pulses: got %0d expected 1", err_pulses); end
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL single_err_count: got %0d expected 1", err_count); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked: got %b expected 1", locked); end

      lock_up();
      for (int i = 1; i <= 300; i++) begin
         step(1'b0, 1'b0, 1'b0);
         step(1'b1, i == 200, 1'b0);
      end
      checks++; if (err_pulses !== 1) begin errors++; $display("FAIL gapped_pulses: got %0d expected 1", err_pulses); end
      checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL gapped_err_count: got %0d expected 1", err_count); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL gapped_locked: got %b expected 1", locked); end
   endtask

   task automatic test_loss_of_lock();
      lock_up();
      repeat (10) step(1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 1'b1, 1'b0);
         if (k == 7) begin
            checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loss_after_7: got %b expected 1", locked); end
         end
      end
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_after_8: got %b expected 0", locked); end
      checks++; if (err_count !== 8'd8) begin errors++; $display("FAIL loss_err_count: got %0d expected 8", err_count); end
      repeat (57) step(1'b1, 1'b0, 1'b0);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_early: got %b expected 0", locked); end
      step(1'b1, 1'b0, 1'b0);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock_at_58: got %b expected 1", locked); end
   endtask

   task automatic test_all_zero();
      logic ever_locked;
      ever_locked = 1'b0;
      do_reset();
      g = 26'h0;
      for (int i = 0; i < 200; i++) begin
         step(1'b1, 1'b0, 1'b0);
         if (locked !== 1'b0) ever_locked = 1'b1;
      end
      checks++; if (ever_locked !== 1'b0) begin errors++; $display("FAIL zero_never_locks: got %b expected 0", ever_locked); end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL zero_err_count: got %0d expected 0", err_count); end
      g = 26'h1;
      repeat (57) step(1'b1, 1'b0, 1'b0);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL zero_then_prbs_early: got %b expected 0", locked); end
      step(1'b1, 1'b0, 1'b0);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL zero_then_prbs_lock: got %b expected 1", locked); end
   endtask

   task automatic test_clr_cnt();
      lock_up();
      repeat (5) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      repeat (5) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
      checks++; if (err_count !== 8'd2) begin errors++; $display("FAIL clr_pre_count: got %0d expected 2", err_count); end
      step(1'b1, 1'b1, 1'b1);
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL clr_wins_count: got %0d expected 0", err_count); end
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL clr_err_still_pulses: got %b expected 1", err); end
`ifdef PRBS26_CHK_BITCNT_EN
      checks++; if (bit_count !== 8'd0) begin errors++; $display("FAIL clr_bit_count: got %0d expected 0", bit_count); end
`endif
      step(1'b1, 1'b0, 1'b0);
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL clr_after_clean: got %0d expected 0", err_count); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clr_keeps_lock: got %b expected 1", locked); end
`ifdef PRBS26_CHK_BITCNT_EN
      checks++; if (bit_count !== 8'd1) begin errors++; $display("FAIL clr_bit_count_restart: got %0d expected 1", bit_count); end
`endif
   endtask

   task automatic test_saturation();
      int   n_err;
      int   idx;
      logic flip;
      n_err = 0;
      idx   = 0;
      lock_up();
      // One error every 10 bits keeps each 64-bit window at 7 errors, below the loss threshold.
      while (n_err < 261) begin
         flip = ((idx % 10) == 5);
         step(1'b1, flip, 1'b0);
         if (flip) begin
            n_err++;
            if (n_err == 100) begin
               checks++; if (err_count !== 8'd100) begin errors++; $display("FAIL sat_mid_count: got %0d expected 100", err_count); end
            end
            if (n_err == 255) begin
               checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_reach_max: got %0d expected 255", err_count); end
            end
         end
         idx++;
      end
      checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_hold_max: got %0d expected 255", err_count); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_locked: got %b expected 1", locked); end
`ifdef PRBS26_CHK_BITCNT_EN
      checks++; if (bit_count !== 8'd255) begin errors++; $display("FAIL sat_bit_count: got %0d expected 255", bit_count); end
`endif
   endtask

   task automatic test_reset_mid();
      lock_up();
      for (int i = 0; i < 40; i++) step(1'b1, (i == 5) || (i == 15) || (i == 25), 1'b0);
      checks++; if (err_count !== 8'd3) begin errors++; $display("FAIL mid_pre_count: got %0d expected 3", err_count); end
`ifdef PRBS26_CHK_BITCNT_EN
      checks++; if (bit_count !== 8'd40) begin errors++; $display("FAIL mid_pre_bit_count: got %0d expected 40", bit_count); end
`endif
      rst = 1'b1;
      step(1'b1, 1'b1, 1'b0);
      rst = 1'b0;
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_rst_locked: got %b expected 0", locked); end
      checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL mid_rst_count: got %0d expected 0", err_count); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_rst_err: got %b expected 0", err); end
`ifdef PRBS26_CHK_BITCNT_EN
      checks++; if (bit_count !== 8'd0) begin errors++; $display("FAIL mid_rst_bit_count: got %0d expected 0", bit_count); end
`endif
      repeat (57) step(1'b1, 1'b0, 1'b0);
      checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_relock_early: got %b expected 0", locked); end
      step(1'b1, 1'b0, 1'b0);
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mid_relock_at_58: got %b expected 1", locked); end
   endtask

   initial begin
      test_reset();
      test_clean_lock();
      test_single_error();
      test_loss_of_lock();
      test_all_zero();
      test_clr_cnt();
      test_saturation();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
